pkt_merger: RTL and testbench
=============================

PKT_MERGER -- requirements
Module: pkt_merger

Interface
REQ-001 Parameter NUM_IN, default 2, number of packet input ports (2..8).
REQ-002 Parameter CNT_BITS, default 32, width of the statistics counters.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 drop_wait_in  input  32  output-stall limit in clk cycles; 0 disables dropping.
REQ-006 pkt_data_in  input  [`PKT_BITS-1:0] x NUM_IN  packet from each assembler pipe.
REQ-007 pkt_vld_in  input  NUM_IN  per-port packet valid.
REQ-008 pkt_rdy_out  output  NUM_IN  per-port ready.
REQ-009 pkt_data_out  output  `PKT_BITS  merged packet.
REQ-010 pkt_vld_out  output  1  merged packet valid.
REQ-011 pkt_rdy_in  input  1  downstream ready.
REQ-012 fwd_cnt_out  output  CNT_BITS  count of packets accepted downstream.
REQ-013 drop_cnt_out  output  CNT_BITS  count of packets dropped on stall timeout.

Function
REQ-014 Every port shall use valid/ready: a transfer occurs on a rising edge where valid and ready are both high.
REQ-015 The block shall hold one output register (pkt_data_out, pkt_vld_out); the register is "free" when pkt_vld_out is low or pkt_rdy_in is high.
REQ-016 Arbitration shall be round-robin: grant goes to the first port with pkt_vld_in high, searching from the priority pointer upward with wrap at NUM_IN-1 to 0.
REQ-017 pkt_rdy_out[i] shall be high only when port i holds the grant and the output register is free (combinational); at most one bit is high at a time.
REQ-018 When port i transfers, the block shall load pkt_data_in[i] into pkt_data_out unmodified and set pkt_vld_out on the same edge: latency is 1 cycle.
REQ-019 After a transfer from port i, the priority pointer shall become (i+1) mod NUM_IN; with no transfer it shall hold.
REQ-020 If the output register is freed and no input is valid, pkt_vld_out shall clear on that edge.
REQ-021 pkt_data_out shall not change while pkt_vld_out is high and pkt_rdy_in is low.
REQ-022 A stall counter shall increment each cycle with pkt_vld_out high and pkt_rdy_in low, and clear otherwise.
REQ-023 With drop_wait_in nonzero, when the stall counter equals drop_wait_in-1 in a stalled cycle, the next edge shall clear pkt_vld_out, clear the stall counter and increment drop_cnt_out; no input is accepted on that edge.
REQ-024 With drop_wait_in zero, packets shall never be dropped.
REQ-025 fwd_cnt_out shall increment on every edge where pkt_vld_out and pkt_rdy_in are both high.
REQ-026 Both counters shall wrap modulo 2^CNT_BITS.
REQ-027 Changing drop_wait_in mid-stall shall take effect on the next comparison; the comparison is against the current value.

Reset
REQ-028 While reset_n is low: pkt_vld_out=0, pkt_rdy_out=0, priority pointer=0, stall counter=0, fwd_cnt_out=0, drop_cnt_out=0; pkt_data_out undefined.
REQ-029 Reset asserted mid-packet shall discard the held packet without counting it as dropped or forwarded.
REQ-030 Reset release shall be synchronised to clk; the first transfer is possible on the second edge after release.

Verification
REQ-031 Port 0 presents 72'h0_12345678_00 with pkt_rdy_in=1 -> pkt_data_out equals it one cycle later, pkt_vld_out=1 for one cycle, fwd_cnt_out=1.
REQ-032 Both ports are valid continuously with pkt_rdy_in=1 for 8 cycles -> grants alternate 0,1,0,1,...; 4 packets from each port; fwd_cnt_out=8.
REQ-033 drop_wait_in=4, one packet, pkt_rdy_in=0 -> pkt_vld_out is high for exactly 4 cycles, then low; drop_cnt_out=1; fwd_cnt_out=0.
REQ-034 drop_wait_in=0, pkt_rdy_in=0 for 1000 cycles, then 1 -> no drop; the packet is delivered intact with data stable throughout.
REQ-035 reset_n is pulled low while a packet is stalled -> outputs return to reset values immediately; both counters remain 0 after release.
REQ-036 Back-to-back stream on port 1 with pkt_rdy_in toggling 1,0,1,0 -> no packet is lost or duplicated; pkt_rdy_out[1] is low in every cycle where the register is not free.

Source files
------------

// File: rtl/pkt_merger.sv
// pkt_merger: round-robin merge of NUM_IN valid/ready packet streams into a
// single registered output, with a stall-timeout drop and forward/drop counters.
//
// Ports
//   clk, reset_n      clock; asynchronous active-low reset (release synchronised)
//   drop_wait_in      output-stall limit in cycles, 0 = never drop
//   pkt_data_in/vld_in/rdy_out   per-port packet inputs (valid/ready)
//   pkt_data_out/vld_out, pkt_rdy_in   merged output register (valid/ready)
//   fwd_cnt_out       packets accepted downstream (wraps)
//   drop_cnt_out      packets dropped on stall timeout (wraps)

`ifndef PKT_BITS
`define PKT_BITS 72
`endif

module pkt_merger #(
    parameter int NUM_IN   = 2,
    parameter int CNT_BITS = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [31:0]                      drop_wait_in,
    input  logic [NUM_IN-1:0][`PKT_BITS-1:0] pkt_data_in,
    input  logic [NUM_IN-1:0]                pkt_vld_in,
    output logic [NUM_IN-1:0]                pkt_rdy_out,
    output logic [`PKT_BITS-1:0]             pkt_data_out,
    output logic                             pkt_vld_out,
    input  logic                             pkt_rdy_in,
    output logic [CNT_BITS-1:0]              fwd_cnt_out,
    output logic [CNT_BITS-1:0]              drop_cnt_out
);

    localparam int PTR_W = $clog2(NUM_IN);

    logic                 run_q;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 vld_q, vld_d;
    logic [`PKT_BITS-1:0] data_q, data_d;
    logic [31:0]          stall_q, stall_d;
    logic [CNT_BITS-1:0]  fwd_q, fwd_d;
    logic [CNT_BITS-1:0]  drop_q, drop_d;

    logic                 gnt_found;
    logic [PTR_W-1:0]     gnt_idx;
    logic                 free, take, stalled, drop;

    // Round-robin search: first pass covers ports at or above the pointer,
    // second pass wraps to the ports below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_found && (i >= int'(ptr_q)) && pkt_vld_in[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (!gnt_found && pkt_vld_in[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(i);
            end
        end
    end

    assign free    = !vld_q || pkt_rdy_in;
    // run_q keeps every ready low until the first edge after reset release.
    assign take    = run_q && free && gnt_found;
    assign stalled = vld_q && !pkt_rdy_in;
    // A stalled register is never free, so a drop edge cannot also accept.
    assign drop    = stalled && (drop_wait_in != 32'd0)
                     && (stall_q == drop_wait_in - 32'd1);

    always_comb begin
        pkt_rdy_out = '0;
        if (take) pkt_rdy_out[gnt_idx] = 1'b1;
    end

    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        stall_d = '0;
        fwd_d   = fwd_q;
        drop_d  = drop_q;
        if (take) begin
            vld_d  = 1'b1;
            data_d = pkt_data_in[gnt_idx];
            ptr_d  = (gnt_idx == PTR_W'(NUM_IN - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end else if (drop || free) begin
            vld_d  = 1'b0;
        end
        if (stalled && !drop) stall_d = stall_q + 32'd1;
        if (drop)                 drop_d = drop_q + CNT_BITS'(1);
        if (vld_q && pkt_rdy_in)  fwd_d  = fwd_q + CNT_BITS'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
            stall_q <= '0;
            fwd_q   <= '0;
            drop_q  <= '0;
        end else begin
            run_q   <= 1'b1;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            stall_q <= stall_d;
            fwd_q   <= fwd_d;
            drop_q  <= drop_d;
        end
    end

    // Payload needs no reset: it is only meaningful while vld_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign pkt_data_out = data_q;
    assign pkt_vld_out  = vld_q;
    assign fwd_cnt_out  = fwd_q;
    assign drop_cnt_out = drop_q;

endmodule

// File: tb/tb_pkt_merger.sv
module tb_pkt_merger;
    localparam int N  = 2;
    localparam int CB = 4;
    localparam int PB = 72;
    localparam int CMOD = 1 << CB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n = 1'b0;
    logic [31:0]          dw = '0;
    logic [N-1:0][PB-1:0] din = '0;
    logic [N-1:0]         vin = '0;
    logic [N-1:0]         pkt_rdy_out;
    logic [PB-1:0]        pkt_data_out;
    logic                 pkt_vld_out;
    logic                 rdy_in = 1'b1;
    logic [CB-1:0]        fwd_cnt_out, drop_cnt_out;

    pkt_merger #(.NUM_IN(N), .CNT_BITS(CB)) dut (
        .clk(clk), .reset_n(reset_n), .drop_wait_in(dw),
        .pkt_data_in(din), .pkt_vld_in(vin), .pkt_rdy_out(pkt_rdy_out),
        .pkt_data_out(pkt_data_out), .pkt_vld_out(pkt_vld_out),
        .pkt_rdy_in(rdy_in), .fwd_cnt_out(fwd_cnt_out), .drop_cnt_out(drop_cnt_out));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_run = 1'b0;
    logic          m_vld = 1'b0;
    logic [PB-1:0] m_data = '0;
    int            m_ptr = 0;
    int unsigned   m_stall = 0;
    int            m_fwd = 0;
    int            m_drop = 0;
    int            gq[$];
    logic [PB-1:0] dq[$];

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (vin[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_rdy();
        logic [N-1:0] r;
        int g;
        r = '0;
        if (m_run && (!m_vld || rdy_in)) begin
            g = m_grant();
            if (g >= 0) r[g] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run   <= 1'b0;
            m_vld   <= 1'b0;
            m_ptr   <= 0;
            m_stall <= 0;
            m_fwd   <= 0;
            m_drop  <= 0;
        end else begin
            automatic logic [N-1:0] r = m_rdy();
            automatic bit st = m_vld && !rdy_in;
            automatic bit dr = st && (dw != 0) && (m_stall == dw - 1);
            m_run <= 1'b1;
            if (m_vld && rdy_in) m_fwd <= (m_fwd + 1) % CMOD;
            if (dr) m_drop <= (m_drop + 1) % CMOD;
            if (r != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (r[i]) begin
                        m_vld  <= 1'b1;
                        m_data <= din[i];
                        m_ptr  <= (i + 1) % N;
                        gq.push_back(i);
                    end
                end
            end else if (!m_vld || rdy_in || dr) begin
                m_vld <= 1'b0;
            end
            m_stall <= (st && !dr) ? m_stall + 1 : 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("rdy_out", pkt_rdy_out, m_rdy());
        chk("vld_out", pkt_vld_out, m_vld);
        if (m_vld) chk("data_out", pkt_data_out, m_data);
        chk("fwd_cnt", fwd_cnt_out, m_fwd);
        chk("drop_cnt", drop_cnt_out, m_drop);
        if (reset_n && pkt_vld_out && rdy_in) dq.push_back(pkt_data_out);
    end

    // ---------------- stimulus ----------------
    task automatic tick(output logic [N-1:0] xm);
        @(negedge clk);
        xm = pkt_rdy_out & vin;
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        logic [N-1:0] xm;
        tick(xm);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        vin = '0;
        tick1();
        tick1();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] xm;
        logic [PB-1:0] a0, b0, seq[6];
        int cnt, idx;

        // T1: single packet, reset synchronisation, one-cycle latency
        do_reset();
        dw = 0; rdy_in = 1'b1;
        din[0] = 72'h0_12345678_00; vin = 2'b01;
        tick1();
        chk("t1_no_xfer_first_edge", pkt_vld_out, 1'b0);
        tick1();
        chk("t1_vld", pkt_vld_out, 1'b1);
        chk("t1_data", pkt_data_out, 72'h0_12345678_00);
        vin = '0;
        tick1();
        chk("t1_vld_clear", pkt_vld_out, 1'b0);
        chk("t1_fwd", fwd_cnt_out, 4'd1);

        // T2: both ports continuously valid -> alternating grants
        do_reset();
        rdy_in = 1'b1;
        a0 = {8'hA0, 64'd0}; b0 = {8'hB0, 64'd0};
        din[0] = a0; din[1] = b0; vin = 2'b11;
        tick1();
        gq.delete(); dq.delete();
        for (int c = 0; c < 8; c++) begin
            tick(xm);
            if (xm[0]) din[0] = din[0] + 1;
            if (xm[1]) din[1] = din[1] + 1;
        end
        vin = '0;
        tick1();
        chk("t2_grants", gq.size(), 8);
        for (int k = 0; k < gq.size() && k < 8; k++) chk("t2_grant_order", gq[k], k % 2);
        chk("t2_fwd", fwd_cnt_out, 4'd8);
        chk("t2_delivered", dq.size(), 8);
        for (int k = 0; k < dq.size() && k < 8; k++)
            chk("t2_payload", dq[k], (k % 2 == 0) ? a0 + PB'(k / 2) : b0 + PB'(k / 2));

        // T3: stall timeout drop with drop_wait_in = 4
        do_reset();
        dw = 4; rdy_in = 1'b0;
        din[0] = 72'h11_2233_4455_6677_8899; vin = 2'b01;
        tick1();
        tick1();
        vin = '0;
        cnt = pkt_vld_out ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            tick1();
            if (pkt_vld_out) cnt++;
            else break;
        end
        chk("t3_vld_cycles", cnt, 4);
        chk("t3_drop", drop_cnt_out, 4'd1);
        chk("t3_fwd", fwd_cnt_out, 4'd0);

        // T3b: limit lowered mid-stall takes effect on the next compare
        dw = 10;
        din[1] = 72'h22_0000_0000_0000_0001; vin = 2'b10;
        tick1();
        vin = '0;
        chk("t3b_loaded", pkt_vld_out, 1'b1);
        tick1();
        tick1();
        dw = 3;
        tick1();
        chk("t3b_dropped", pkt_vld_out, 1'b0);
        chk("t3b_drop", drop_cnt_out, 4'd2);

        // T4: drop disabled, 1000-cycle stall, then delivery
        do_reset();
        dw = 0; rdy_in = 1'b0;
        din[1] = 72'hDE_ADBEEF_CAFEF00D; vin = 2'b10;
        tick1();
        tick1();
        vin = '0; din[1] = '0;
        repeat (1000) tick1();
        chk("t4_still_held", pkt_vld_out, 1'b1);
        chk("t4_stable", pkt_data_out, 72'hDE_ADBEEF_CAFEF00D);
        dq.delete();
        rdy_in = 1'b1;
        tick1();
        chk("t4_delivered", dq.size(), 1);
        if (dq.size() > 0) chk("t4_payload", dq[0], 72'hDE_ADBEEF_CAFEF00D);
        chk("t4_drop", drop_cnt_out, 4'd0);
        chk("t4_fwd", fwd_cnt_out, 4'd1);

        // T5: reset while a packet is stalled
        do_reset();
        dw = 0; rdy_in = 1'b0;
        din[0] = 72'h55; vin = 2'b01;
        tick1();
        tick1();
        repeat (3) tick1();
        rdy_in = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("t5_vld_reset", pkt_vld_out, 1'b0);
        chk("t5_rdy_reset", pkt_rdy_out, 2'b00);
        chk("t5_fwd_reset", fwd_cnt_out, 4'd0);
        tick1();
        reset_n = 1'b1; vin = '0;
        repeat (3) tick1();
        chk("t5_fwd_after", fwd_cnt_out, 4'd0);
        chk("t5_drop_after", drop_cnt_out, 4'd0);

        // T6: back-to-back stream on port 1 with toggling downstream ready
        do_reset();
        dw = 0;
        for (int k = 0; k < 6; k++) seq[k] = {8'hC1, 64'(k * 7 + 3)};
        tick1();
        dq.delete(); gq.delete();
        idx = 0;
        for (int c = 0; c < 40 && dq.size() < 6; c++) begin
            rdy_in = (c % 2 == 0);
            vin = (idx < 6) ? 2'b10 : 2'b00;
            din[1] = (idx < 6) ? seq[idx] : '0;
            tick(xm);
            if (xm[1]) idx++;
        end
        vin = '0;
        chk("t6_accepted", idx, 6);
        chk("t6_delivered", dq.size(), 6);
        for (int k = 0; k < dq.size() && k < 6; k++) chk("t6_payload", dq[k], seq[k]);

        // T7: forward counter wraps modulo 2^CNT_BITS
        do_reset();
        rdy_in = 1'b1; din[0] = 72'h7; vin = 2'b01;
        tick1();
        repeat (18) tick1();
        vin = '0;
        tick1();
        chk("t7_fwd_wrap", fwd_cnt_out, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
